// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter steering a shared 4:1 data mux onto one valid/ready channel,
// holding each grant for at most MAX_BURST beats before rotating priority.
module rr_mux_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      ack,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  input  logic            dout_ready
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q, ptr_q, pick, idx;
  logic [3:0] cnt_q;
  logic       found, granted, live;
  always_comb begin
    pick  = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  assign granted    = state_q == GRANT;
  assign live       = granted & req[sel_q];
  assign dout_valid = live;
  assign dout       = granted ? din[sel_q*DW +: DW] : '0;
  assign ack        = (live & dout_ready) ? 4'b0001 << sel_q : 4'b0000;
  assign gnt        = gnt_q;
  assign sel        = sel_q;
  // Release happens on withdrawal or on the final beat; sel keeps its value so ptr can follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (found) begin
        sel_q   <= pick;
        gnt_q   <= 4'b0001 << pick;
        cnt_q   <= '0;
        state_q <= GRANT;
      end
    end else if (!req[sel_q] || (dout_ready && cnt_q + 4'd1 == 4'(MAX_BURST))) begin
      ptr_q   <= sel_q + 2'd1;
      gnt_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= dout_ready && req[sel_q] ? cnt_q + 4'd1 : cnt_q;
    end else if (dout_ready) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end
endmodule
